// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint monitor: matches an ordered table of expected status values on a
// registered status bus, with stability filtering and a per-step timeout.
module checkpoint_seq_monitor #(
    parameter int unsigned CHECK_W    = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIMEOUT_W  = 32,
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [CHECK_W-1:0]         checkbits,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [CHECK_W-1:0]         cfg_data,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [TIMEOUT_W-1:0]       timeout_cyc,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [$clog2(DEPTH)-1:0]   match_idx,
    output logic                       match_pulse,
    output logic [TIMEOUT_W-1:0]       elapsed
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned STAB_W = $clog2(STABLE_CYC + 1);
    localparam logic [IDX_W:0]      DEPTH_L = (IDX_W + 1)'(DEPTH);
    localparam logic [STAB_W-1:0]   STAB_L  = STAB_W'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t                state;
    state_t                state_next;
    logic [CHECK_W-1:0]    exp_tab [DEPTH];
    logic [CHECK_W-1:0]    chk_q;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W:0]        len_q;
    logic [TIMEOUT_W-1:0]  timeout_q;
    logic [TIMEOUT_W-1:0]  step_cnt;
    logic [STAB_W-1:0]     stab_cnt;
    logic                  do_start;
    logic                  do_match;
    logic                  do_timeout;
    logic                  is_last;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completed stability window is acted on one edge after it fills, so the
    // match decision outranks a timeout landing on the same edge.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_match   = 1'b0;
        do_timeout = 1'b0;
        is_last    = ({1'b0, idx} == (len_q - (IDX_W + 1)'(1)));
        case (state)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (len_q == '0) begin
                    state_next = PASS;
                end else if (stab_cnt == STAB_L) begin
                    do_match = 1'b1;
                    if (is_last) begin
                        state_next = PASS;
                    end
                end else if ((timeout_q != '0) && (step_cnt == timeout_q - TIMEOUT_W'(1))) begin
                    do_timeout = 1'b1;
                    state_next = FAIL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            chk_q       <= '0;
            idx         <= '0;
            len_q       <= '0;
            timeout_q   <= '0;
            step_cnt    <= '0;
            stab_cnt    <= '0;
            match_idx   <= '0;
            match_pulse <= 1'b0;
            elapsed     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                exp_tab[i] <= '0;
            end
        end else begin
            chk_q       <= checkbits;
            match_pulse <= do_match;
            if (cfg_we && (state != RUN)) begin
                exp_tab[cfg_addr] <= cfg_data;
            end
            if (do_start) begin
                idx       <= '0;
                stab_cnt  <= '0;
                step_cnt  <= '0;
                elapsed   <= '0;
                match_idx <= '0;
                len_q     <= (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
                timeout_q <= timeout_cyc;
            end else if (state == RUN) begin
                if (elapsed != '1) begin
                    elapsed <= elapsed + TIMEOUT_W'(1);
                end
                if (do_match) begin
                    match_idx <= idx;
                    idx       <= idx + IDX_W'(1);
                    stab_cnt  <= '0;
                    step_cnt  <= '0;
                end else begin
                    if (do_timeout) begin
                        match_idx <= idx;
                    end
                    step_cnt <= step_cnt + TIMEOUT_W'(1);
                    stab_cnt <= (chk_q == exp_tab[idx]) ? stab_cnt + STAB_W'(1) : '0;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Self-checking bench for checkpoint_seq_monitor: directed scenarios plus random
// waveforms, predicted from whole-run sample arrays by a window-search model.
module tb_checkpoint_seq_monitor;

    localparam int NW    = 1024;
    localparam int DEPTH = 8;
    localparam int SC    = 2;

    logic        clk = 1'b0;
    logic        rst, start, cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data, checkbits;
    logic [3:0]  cfg_len;
    logic [31:0] timeout_cyc;
    logic        busy, done, pass, fail, match_pulse;
    logic [2:0]  match_idx;
    logic [31:0] elapsed;

    int errors = 0;
    int checks = 0;

    logic [15:0] v [NW];
    logic [15:0] model_exp [DEPTH];
    bit          mp_exp [NW];
    int          kexp [NW];
    int          end_edge, end_idx, wp;
    bit          end_pass;
    int          mp_seen [$];
    int          done_seen;
    logic [15:0] t1 [6] = '{16'hAB40, 16'h0028, 16'h037D, 16'h09ED, 16'h0A6D, 16'hAB62};

    checkpoint_seq_monitor #(.CHECK_W(16), .DEPTH(8), .TIMEOUT_W(32), .STABLE_CYC(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .checkbits(checkbits), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .timeout_cyc(timeout_cyc), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .match_idx(match_idx), .match_pulse(match_pulse),
        .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclear();
        wp = 0;
        for (int i = 0; i < NW; i++) v[i] = '0;
    endtask

    task automatic seg(input logic [15:0] val, input int n);
        for (int i = 0; i < n; i++) if (wp < NW) begin v[wp] = val; wp++; end
    endtask

    task automatic pad(input logic [15:0] val);
        while (wp < NW) begin v[wp] = val; wp++; end
    endtask

    task automatic write_entry(input int addr, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        model_exp[addr] = data;
    endtask

    // Edge 0 is the start edge and samples v[0]; entry k matches at the first
    // edge n whose SC preceding samples v[n-1-SC..n-2] equal it, all taken
    // after the previous match edge m; a timeout T ends the step at m+T.
    task automatic predict(input int len_in, input int t);
        int  len, m, k, n;
        bit  found, ok;
        len = (len_in > DEPTH) ? DEPTH : len_in;
        for (int j = 0; j < NW; j++) begin mp_exp[j] = 0; kexp[j] = 0; end
        end_edge = -1; end_pass = 0; end_idx = 0;
        if (len == 0) begin end_edge = 1; end_pass = 1; return; end
        m = 0; k = 0;
        forever begin
            found = 0;
            for (n = m + SC + 1; n < NW; n++) begin
                ok = 1;
                for (int i = 2; i <= SC + 1; i++) if (v[n-i] !== model_exp[k]) ok = 0;
                if (ok) begin found = 1; break; end
            end
            if (t != 0 && (!found || n > m + t)) begin
                end_edge = m + t; end_pass = 0; end_idx = k; return;
            end
            if (!found) return;
            mp_exp[n] = 1; kexp[n] = k;
            if (k == len - 1) begin end_edge = n; end_pass = 1; end_idx = k; return; end
            k++; m = n;
        end
    endtask

    task automatic run(input string name, input int len, input int t, input int we_edge,
                       input int we_addr, input logic [15:0] we_data, input int restart_edge,
                       input int abort_edge);
        bit ended = 0;
        if (we_edge == 0) model_exp[we_addr] = we_data;
        predict(len, t);
        mp_seen.delete();
        done_seen = -1;
        for (int j = 0; j < NW; j++) begin
            @(negedge clk);
            checkbits   = v[j];
            start       = (j == 0) || (j == restart_edge);
            cfg_len     = 4'(len);
            timeout_cyc = 32'(t);
            cfg_we      = (j == we_edge);
            cfg_addr    = 3'(we_addr);
            cfg_data    = we_data;
            @(posedge clk);
            #1;
            if (match_pulse === 1'b1) mp_seen.push_back(j);
            if (done === 1'b1 && done_seen < 0) done_seen = j;
            check({name, " match_pulse"}, match_pulse, mp_exp[j]);
            if (mp_exp[j]) check({name, " match_idx@pulse"}, match_idx, kexp[j]);
            check({name, " busy"}, busy, (end_edge < 0) || (j < end_edge));
            if (j == abort_edge) begin ended = 1; break; end
            if (j == end_edge) begin
                ended = 1;
                check({name, " done"}, done, 1);
                check({name, " pass"}, pass, end_pass);
                check({name, " fail"}, fail, !end_pass);
                check({name, " match_idx@end"}, match_idx, end_idx);
                check({name, " elapsed"}, elapsed, end_edge);
                break;
            end
        end
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        check({name, " finished within bound"}, ended, 1);
        if (abort_edge < 0 && end_edge >= 0) begin
            repeat (2) @(negedge clk);
            check({name, " done held"}, done, 1);
            check({name, " elapsed frozen"}, elapsed, end_edge);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_exp[i] = '0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " pass"}, pass, 0);
        check({name, " fail"}, fail, 0);
        check({name, " match_idx"}, match_idx, 0);
        check({name, " match_pulse"}, match_pulse, 0);
        check({name, " elapsed"}, elapsed, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        checkbits = '0; cfg_len = '0; timeout_cyc = '0;
        do_reset();
        check_idle_outputs("reset");

        // Empty list passes one edge after start with no pulse.
        wclear(); pad(16'h0000);
        run("len0", 0, 0, -1, 0, 16'h0, -1, -1);
        check("len0 no pulse", mp_seen.size(), 0);

        // Six-entry sequence; entry 0 written in the start cycle over a stale value.
        write_entry(0, 16'h1234);
        for (int k = 1; k < 6; k++) write_entry(k, t1[k]);
        wclear(); for (int k = 0; k < 6; k++) seg(t1[k], 5); pad(16'h0000);
        run("seq6", 6, 0, 0, 0, t1[0], -1, -1);
        check("seq6 pulse count", mp_seen.size(), 6);

        // Single-cycle blip is filtered; a two-cycle hold matches 3 clocks later.
        write_entry(0, 16'h0028);
        wclear(); seg(16'h0000, 4); seg(16'h0028, 1); seg(16'h0000, 4); seg(16'h0028, 2);
        pad(16'h0000);
        run("blip", 1, 0, -1, 0, 16'h0, -1, -1);
        check("blip pulse count", mp_seen.size(), 1);
        if (mp_seen.size() > 0) check("blip latency", mp_seen[0], 9 + 3);

        // Entry 1 never appears: fail exactly 100 cycles after the entry-0 match.
        write_entry(0, t1[0]);
        wclear(); seg(t1[0], 5); pad(16'h0000);
        run("timeout", 6, 100, -1, 0, 16'h0, -1, -1);
        if (mp_seen.size() > 0) check("timeout distance", done_seen - mp_seen[0], 100);
        check("timeout match_idx", match_idx, 1);

        // Entry 1 stable exactly at the limit; a write during RUN must be dropped.
        wclear(); seg(t1[0], 3); seg(16'h0000, 7); pad(t1[1]);
        run("edge_limit", 2, 10, 6, 1, 16'hFFFF, -1, -1);
        check("edge_limit second match at limit", mp_seen.size() == 2 ? mp_seen[1] - mp_seen[0] : -1, 10);
        run("table_kept", 2, 10, -1, 0, 16'h0, -1, -1);
        check("table_kept pass", pass, 1);

        // Random tables and waveforms with ignored restarts and in-run writes.
        for (int r = 0; r < 8; r++) begin
            int len, t;
            for (int k = 0; k < DEPTH; k++)
                write_entry(k, (k > 0 && $urandom_range(0, 3) == 0) ? model_exp[k-1] : 16'($urandom));
            wclear();
            while (wp < NW)
                seg(($urandom_range(0, 2) != 0) ? model_exp[$urandom_range(0, DEPTH - 1)] : 16'($urandom),
                    int'($urandom_range(1, 5)));
            len = int'($urandom_range(0, 12));
            t   = int'($urandom_range(12, 40));
            run($sformatf("rand%0d", r), len, t, int'($urandom_range(1, 20)),
                int'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(1, 20)), -1);
        end

        // Reset after two matches clears everything, including the table.
        for (int k = 0; k < 6; k++) write_entry(k, t1[k]);
        wclear(); for (int k = 0; k < 6; k++) seg(t1[k], 5); pad(16'h0000);
        run("pre_reset", 6, 0, -1, 0, 16'h0, -1, 10);
        check("pre_reset matches", mp_seen.size(), 2);
        do_reset();
        check_idle_outputs("mid_reset");
        wclear(); pad(16'h0000);
        run("cleared_table", 8, 0, -1, 0, 16'h0, -1, -1);
        check("cleared_table pulses", mp_seen.size(), 8);
        for (int k = 0; k < 6; k++) write_entry(k, t1[k]);
        wclear(); for (int k = 0; k < 6; k++) seg(t1[k], 5); pad(16'h0000);
        run("reload", 6, 0, -1, 0, 16'h0, -1, -1);
        check("reload pulses", mp_seen.size(), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
